// File: rtl/sleep_ctrl.sv
// Multi-channel sleep controller: each channel stalls its core for a number of
// big-clock ticks (slp) or until its XBus port reports ready (slx).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | channel awake, accepting start
// S_TIMED | counting down big-clock ticks, remaining = cnt
// S_XWAIT | stalled until xbus_ready is seen high
module sleep_ctrl #(
    parameter int CHANNELS  = 4,
    parameter int VAL_WIDTH = 11,
    parameter int MAX_SLEEP = 999
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            posedge_big_clk,
    input  logic [CHANNELS-1:0]             start,
    input  logic [CHANNELS-1:0]             mode,
    input  logic [CHANNELS*VAL_WIDTH-1:0]   sleep_val,
    input  logic [CHANNELS-1:0]             xbus_ready,
    input  logic [CHANNELS-1:0]             abort,
    output logic [CHANNELS-1:0]             sleeping,
    output logic [CHANNELS-1:0]             wake,
    output logic [CHANNELS*VAL_WIDTH-1:0]   remaining,
    output logic                            any_sleeping
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TIMED = 2'd1,
        S_XWAIT = 2'd2
    } state_t;

    localparam logic signed [VAL_WIDTH-1:0] MAX_S  = VAL_WIDTH'(MAX_SLEEP);
    localparam logic signed [VAL_WIDTH-1:0] ZERO_S = '0;
    localparam logic        [VAL_WIDTH-1:0] ONE    = VAL_WIDTH'(1);

    state_t                  state_q [CHANNELS];
    state_t                  state_d [CHANNELS];
    logic [VAL_WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [VAL_WIDTH-1:0]    cnt_d   [CHANNELS];
    logic signed [VAL_WIDTH-1:0] val_s [CHANNELS];

    logic [CHANNELS-1:0]     sleeping_q, sleeping_d;
    logic [CHANNELS-1:0]     wake_q, wake_d;
    logic                    any_sleeping_q, any_sleeping_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            val_s[i] = $signed(sleep_val[i*VAL_WIDTH +: VAL_WIDTH]);
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        wake_d = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            if (abort[i]) begin
                // Abort wins over everything; a start in the same cycle is dropped.
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
                wake_d[i]  = (state_q[i] != S_IDLE);
            end else begin
                unique case (state_q[i])
                    S_IDLE: begin
                        if (start[i]) begin
                            if (!mode[i]) begin
                                if (val_s[i] <= ZERO_S) begin
                                    wake_d[i] = 1'b1;
                                end else begin
                                    state_d[i] = S_TIMED;
                                    cnt_d[i]   = (val_s[i] > MAX_S) ? MAX_S : val_s[i];
                                end
                            end else if (xbus_ready[i]) begin
                                wake_d[i] = 1'b1;
                            end else begin
                                state_d[i] = S_XWAIT;
                            end
                        end
                    end
                    S_TIMED: begin
                        if (posedge_big_clk) begin
                            if (cnt_q[i] <= ONE) begin
                                state_d[i] = S_IDLE;
                                cnt_d[i]   = '0;
                                wake_d[i]  = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] - ONE;
                            end
                        end
                    end
                    S_XWAIT: begin
                        if (xbus_ready[i]) begin
                            state_d[i] = S_IDLE;
                            wake_d[i]  = 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end

        for (int i = 0; i < CHANNELS; i++) begin
            sleeping_d[i] = (state_d[i] != S_IDLE);
        end
        any_sleeping_d = |sleeping_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            sleeping_q     <= '0;
            wake_q         <= '0;
            any_sleeping_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sleeping_q     <= sleeping_d;
            wake_q         <= wake_d;
            any_sleeping_q <= any_sleeping_d;
        end
    end

    // cnt is held at zero outside TIMED, so it can drive remaining directly.
    always_comb begin
        remaining = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            remaining[i*VAL_WIDTH +: VAL_WIDTH] = cnt_q[i];
        end
    end

    assign sleeping     = sleeping_q;
    assign wake         = wake_q;
    assign any_sleeping = any_sleeping_q;

endmodule
